// File: rtl/ram8_reg16.sv
// Eight-word x 16-bit register bank: DMux8Way load steering, per-word hold-mux flops, Mux8Way16 read.
// Optional write-through read path enabled by defining READ_BYPASS_EN.
module ram8_reg16 #(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [0:WIDTH-1]     RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] in,
  input  logic             load,
  input  logic [0:2]       address,
  output logic [0:WIDTH-1] out
);

  if (WIDTH != 16) begin : g_width_check
    $error("ram8_reg16 supports WIDTH=16 only");
  end

  // address[0] is the least significant select bit despite the ascending declaration.
  logic [2:0]       sel;
  logic [7:0]       load_k;
  logic [0:WIDTH-1] words [8];
  logic [0:WIDTH-1] stored;

  always_comb begin
    sel = {address[2], address[1], address[0]};
  end

  always_comb begin
    load_k      = '0;
    load_k[sel] = load;
  end

  for (genvar g = 0; g < 8; g++) begin : g_word
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        words[g] <= RESET_VAL;
      end else if (load_k[g]) begin
        words[g] <= in;
      end
    end
  end

  always_comb begin
    stored = words[sel];
  end

`ifdef READ_BYPASS_EN
  always_comb begin
    out = (rst_n && load) ? in : stored;
  end
`else
  always_comb begin
    out = stored;
  end
`endif

endmodule
